// File: rtl/wb_check_pkg.sv
// rtl/wb_check_pkg.sv - shared state and failure-code definitions for the writeback checker
package wb_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_RD      = 2'd1;
    localparam logic [1:0] FC_DATA    = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

endpackage

// File: rtl/wb_exp_table.sv
// rtl/wb_exp_table.sv - expected-write table, synchronous write, combinational read
module wb_exp_table #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [4:0]               i_wrd,
    input  logic [XLEN-1:0]          i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [4:0]               o_rd,
    output logic [XLEN-1:0]          o_data
);

    // Contents deliberately survive reset so a table can be loaded once and re-run.
    logic [XLEN+4:0] r_mem [DEPTH];

    // Table write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= {i_wrd, i_wdata};
        end
    end

    assign {o_rd, o_data} = r_mem[i_raddr];

endmodule

// File: rtl/wb_retire_checker.sv
// rtl/wb_retire_checker.sv - in-order scoreboard of retired register writes with timeout
module wb_retire_checker
    import wb_check_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     exp_we,
    input  logic [$clog2(DEPTH)-1:0] exp_addr,
    input  logic [4:0]               exp_rd,
    input  logic [XLEN-1:0]          exp_data,
    input  logic [$clog2(DEPTH):0]   num_expected,
    input  logic                     start,
    input  logic                     wb_en,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [1:0]               fail_code,
    output logic [$clog2(DEPTH)-1:0] fail_index,
    output logic [4:0]               got_rd,
    output logic [XLEN-1:0]          got_data,
    output logic [CNT_W-1:0]         cycle_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_idx;
    logic [CW-1:0]     r_count;
    logic [TW-1:0]     r_timer;
    logic [CNT_W-1:0]  r_cc;
    logic [1:0]        r_fail_code;
    logic [AW-1:0]     r_fail_index;
    logic [4:0]        r_got_rd;
    logic [XLEN-1:0]   r_got_data;

    logic [4:0]        w_exp_rd;
    logic [XLEN-1:0]   w_exp_data;
    logic [CW-1:0]     w_count_in;
    logic [CW-1:0]     w_idx_inc;
    logic              w_zero;
    logic              w_wb_act;
    logic              w_match;
    logic              w_rd_err;
    logic              w_data_err;
    logic              w_last;
    logic              w_timeout;
    logic              w_arm;

    // Table loads are only honoured outside RUN so the sequence under check cannot shift.
    wb_exp_table #(.XLEN(XLEN), .DEPTH(DEPTH)) u_table (
        .clk     (clk),
        .i_we    (exp_we && (r_state != RUN)),
        .i_waddr (exp_addr),
        .i_wrd   (exp_rd),
        .i_wdata (exp_data),
        .i_raddr (r_idx),
        .o_rd    (w_exp_rd),
        .o_data  (w_exp_data)
    );

    assign w_count_in = (num_expected > CW'(DEPTH)) ? CW'(DEPTH) : num_expected;
    assign w_arm      = start && (r_state != RUN);
    assign w_zero     = (r_count == '0);
    // x0 writes are architecturally discarded, so they never consume a table entry.
    assign w_wb_act   = wb_en && (wb_rd != 5'd0) && !w_zero;
    assign w_rd_err   = w_wb_act && (wb_rd != w_exp_rd);
    assign w_data_err = w_wb_act && (wb_rd == w_exp_rd) && (wb_data != w_exp_data);
    assign w_match    = w_wb_act && (wb_rd == w_exp_rd) && (wb_data == w_exp_data);
    assign w_idx_inc  = {1'b0, r_idx} + CW'(1);
    assign w_last     = w_match && (w_idx_inc == r_count);
    assign w_timeout  = !w_wb_act && !w_zero && (r_timer == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a match takes priority over an expiring timer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_zero) begin
                    w_state_nxt = PASS;
                end else if (w_rd_err || w_data_err || w_timeout) begin
                    w_state_nxt = FAIL;
                end else if (w_last) begin
                    w_state_nxt = PASS;
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
        endcase
    end

    // Scoreboard pointer, timers and failure diagnostics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx        <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_cc         <= '0;
            r_fail_code  <= FC_NONE;
            r_fail_index <= '0;
            r_got_rd     <= '0;
            r_got_data   <= '0;
        end else if (w_arm) begin
            r_idx        <= '0;
            r_count      <= w_count_in;
            r_timer      <= '0;
            r_cc         <= '0;
            r_fail_code  <= FC_NONE;
            r_fail_index <= '0;
            r_got_rd     <= '0;
            r_got_data   <= '0;
        end else if (r_state == RUN) begin
            if (r_cc != '1) begin
                r_cc <= r_cc + CNT_W'(1);
            end
            if (!w_zero) begin
                if (w_match) begin
                    r_idx   <= w_idx_inc[AW-1:0];
                    r_timer <= '0;
                end else if (w_rd_err || w_data_err) begin
                    r_fail_code  <= w_rd_err ? FC_RD : FC_DATA;
                    r_fail_index <= r_idx;
                    r_got_rd     <= wb_rd;
                    r_got_data   <= wb_data;
                end else if (w_timeout) begin
                    r_fail_code  <= FC_TIMEOUT;
                    r_fail_index <= r_idx;
                end else begin
                    r_timer <= r_timer + TW'(1);
                end
            end
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == PASS) || (r_state == FAIL);
    assign pass        = (r_state == PASS);
    assign fail_code   = r_fail_code;
    assign fail_index  = r_fail_index;
    assign got_rd      = r_got_rd;
    assign got_data    = r_got_data;
    assign cycle_count = r_cc;

endmodule
